// File: rtl/interrupt_controller_if.sv
// Interrupt controller bus interface.
// Groups the IRQ lines, mask-load bus, ack/done handshake and the
// request/status outputs of interrupt_controller.
//   master : drives irq_in, BusIn, MaskIn, IntAck, IntDone (control unit side)
//   slave  : the interrupt controller itself
interface interrupt_controller_if #(
  parameter int InterruptsNum = 2
);
  localparam int VEC_W = (InterruptsNum > 1) ? $clog2(InterruptsNum) : 1;

  logic [InterruptsNum-1:0] irq_in;
  logic [31:0]              BusIn;
  logic                     MaskIn;
  logic                     IntAck;
  logic                     IntDone;
  logic [InterruptsNum-1:0] interrupt;
  logic [VEC_W-1:0]         IntVector;
  logic                     IntActive;
  logic [31:0]              StatusOut;

  modport master (
    output irq_in, BusIn, MaskIn, IntAck, IntDone,
    input  interrupt, IntVector, IntActive, StatusOut
  );

  modport slave (
    input  irq_in, BusIn, MaskIn, IntAck, IntDone,
    output interrupt, IntVector, IntActive, StatusOut
  );
endinterface

// File: rtl/interrupt_controller.sv
// Interrupt controller feeding the control unit's interrupt input.
// Per line: 2-flop synchroniser, rising-edge detect, pending latch.
// Shared: software mask, fixed lowest-index-first arbitration, and an
// IDLE -> REQ -> SERVICE handshake holding one one-hot grant (no nesting).
// Ports:
//   Clock      system clock (posedge)
//   Reset      synchronous, active-high
//   bus.slave  irq_in / BusIn / MaskIn / IntAck / IntDone in,
//              interrupt / IntVector / IntActive / StatusOut out

// One IRQ line: synchroniser, edge detect, pending bit.
// Ports: i_clk, i_rst, i_irq (raw line), i_clr (ack clear), o_pending.
module interrupt_controller_lane (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_irq,
  input  logic i_clr,
  output logic o_pending
);
  logic r_s1, r_s2, r_h, r_pend;
  logic w_edge;

  assign w_edge = r_s2 & ~r_h;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_h    <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_s1   <= i_irq;
      r_s2   <= r_s1;
      r_h    <= r_s2;
      // a fresh edge beats a same-cycle ack clear so the new event survives
      r_pend <= w_edge | (r_pend & ~i_clr);
    end
  end

  assign o_pending = r_pend;
endmodule

module interrupt_controller #(
  parameter int InterruptsNum = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  interrupt_controller_if.slave bus
);
  localparam int VEC_W = (InterruptsNum > 1) ? $clog2(InterruptsNum) : 1;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t                   r_state, w_next;
  logic [InterruptsNum-1:0] r_mask, r_grant;
  logic [InterruptsNum-1:0] w_pend, w_clr, w_elig, w_first;
  logic                     w_unused_bus;

  assign w_unused_bus = ^bus.BusIn[31:InterruptsNum];

  // pending clears only for the granted line, on the accepting ack
  assign w_clr   = (r_state == REQ && bus.IntAck) ? r_grant : '0;
  assign w_elig  = w_pend & r_mask;
  // isolate lowest set bit: lowest index has highest priority
  assign w_first = w_elig & (~w_elig + 1'b1);

  genvar g;
  generate
    for (g = 0; g < InterruptsNum; g++) begin : g_lane
      interrupt_controller_lane u_lane (
        .i_clk     (Clock),
        .i_rst     (Reset),
        .i_irq     (bus.irq_in[g]),
        .i_clr     (w_clr[g]),
        .o_pending (w_pend[g])
      );
    end
  endgenerate

  always_ff @(posedge Clock) begin
    if (Reset)           r_mask <= '0;
    else if (bus.MaskIn) r_mask <= bus.BusIn[InterruptsNum-1:0];
  end

  // grant is frozen from IDLE exit until the handler reports done
  always_ff @(posedge Clock) begin
    if (Reset)                                r_grant <= '0;
    else if (r_state == IDLE && |w_elig)      r_grant <= w_first;
    else if (r_state == SERVICE && bus.IntDone) r_grant <= '0;
  end

  always_ff @(posedge Clock) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (|w_elig)     w_next = REQ;
      REQ:     if (bus.IntAck)  w_next = SERVICE;  // done ignored here
      SERVICE: if (bus.IntDone) w_next = IDLE;
      default:                  w_next = IDLE;
    endcase
  end

  // outputs decode registered state only
  always_comb begin
    bus.interrupt = '0;
    bus.IntVector = '0;
    bus.IntActive = (r_state == SERVICE);
    if (r_state == REQ) begin
      bus.interrupt = r_grant;
      for (int i = 0; i < InterruptsNum; i++)
        if (r_grant[i]) bus.IntVector = VEC_W'(i);
    end
    bus.StatusOut                      = '0;
    bus.StatusOut[InterruptsNum-1:0]   = w_pend;
    bus.StatusOut[16 +: InterruptsNum] = r_mask;
  end
endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;
  localparam int N  = 2;
  localparam int VW = 1;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  interrupt_controller_if #(.InterruptsNum(N)) bus ();
  interrupt_controller #(.InterruptsNum(N)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));

  int checks = 0, failures = 0;

  // Reference model: irq history of the last three clock samples,
  // a pending set, and "which line is presented / being serviced".
  logic [N-1:0] m_hist [3] = '{default: '0};
  logic [N-1:0] m_pend = '0, m_mask = '0, m_rise, m_elig;
  int           m_cur = 0;
  bit           m_present = 0, m_serv = 0;

  always @(posedge Clock) begin
    if (Reset) begin
      m_hist = '{default: '0};
      m_pend = '0; m_mask = '0; m_cur = 0; m_present = 0; m_serv = 0;
    end else begin
      // a rise seen at sample n-2 reaches pending at edge n
      m_rise = m_hist[1] & ~m_hist[2];
      m_elig = m_pend & m_mask;
      if (m_present && bus.IntAck) m_pend[m_cur] = 1'b0;
      m_pend = m_pend | m_rise;
      if (bus.MaskIn) m_mask = bus.BusIn[N-1:0];
      if (!m_present && !m_serv) begin
        for (int i = N-1; i >= 0; i--) if (m_elig[i]) m_cur = i;
        if (m_elig != 0) m_present = 1;
      end else if (m_present) begin
        if (bus.IntAck) begin m_present = 0; m_serv = 1; end
      end else if (bus.IntDone) begin
        m_serv = 0;
      end
      m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = bus.irq_in;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic do_reset();
    Reset = 1; bus.irq_in = '0; bus.BusIn = '0; bus.MaskIn = 0;
    bus.IntAck = 0; bus.IntDone = 0;
    tick(1);
    Reset = 0;
  endtask

  task automatic load_mask(input logic [N-1:0] m);
    bus.BusIn = 32'(m); bus.MaskIn = 1;
    tick(1);
    bus.MaskIn = 0; bus.BusIn = '0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.interrupt !== 2'b00) begin failures++; $display("FAIL reset_int got %b exp 00", bus.interrupt); end
    checks++; if (bus.IntVector !== 1'b0) begin failures++; $display("FAIL reset_vec got %b exp 0", bus.IntVector); end
    checks++; if (bus.IntActive !== 1'b0) begin failures++; $display("FAIL reset_act got %b exp 0", bus.IntActive); end
    checks++; if (bus.StatusOut !== 32'h0) begin failures++; $display("FAIL reset_status got %h exp 0", bus.StatusOut); end
    bus.irq_in = 2'b11;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      checks++; if (bus.interrupt !== 2'b00) begin failures++; $display("FAIL masked_int cyc %0d got %b exp 00", k, bus.interrupt); end
    end
    checks++; if (bus.StatusOut !== 32'h0000_0003) begin failures++; $display("FAIL masked_status got %h exp 00000003", bus.StatusOut); end
  endtask

  task automatic test_single();
    do_reset();
    load_mask(2'b01);
    bus.irq_in = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      checks++;
      if (bus.interrupt !== ((k == 4) ? 2'b01 : 2'b00)) begin
        failures++; $display("FAIL latency posedge %0d got %b exp %b", k, bus.interrupt, (k == 4) ? 2'b01 : 2'b00);
      end
    end
    checks++; if (bus.IntVector !== 1'b0) begin failures++; $display("FAIL single_vec got %b exp 0", bus.IntVector); end
    for (int k = 0; k < 5; k++) begin
      tick(1);
      checks++; if (bus.interrupt !== 2'b01) begin failures++; $display("FAIL hold_noack cyc %0d got %b exp 01", k, bus.interrupt); end
    end
    bus.IntAck = 1; tick(1); bus.IntAck = 0;
    checks++; if (bus.interrupt !== 2'b00) begin failures++; $display("FAIL ack_int got %b exp 00", bus.interrupt); end
    checks++; if (bus.IntActive !== 1'b1) begin failures++; $display("FAIL ack_active got %b exp 1", bus.IntActive); end
    checks++; if (bus.StatusOut !== 32'h0001_0000) begin failures++; $display("FAIL ack_status got %h exp 00010000", bus.StatusOut); end
    bus.IntDone = 1; tick(1); bus.IntDone = 0;
    checks++; if (bus.IntActive !== 1'b0) begin failures++; $display("FAIL done_active got %b exp 0", bus.IntActive); end
    tick(3);
    checks++; if (bus.interrupt !== 2'b00) begin failures++; $display("FAIL level_noretrig got %b exp 00", bus.interrupt); end
  endtask

  task automatic test_priority();
    do_reset();
    load_mask(2'b11);
    bus.irq_in = 2'b11;
    tick(4);
    checks++; if (bus.interrupt !== 2'b01) begin failures++; $display("FAIL prio_first got %b exp 01", bus.interrupt); end
    bus.IntAck = 1; tick(1); bus.IntAck = 0;
    bus.IntDone = 1; tick(1); bus.IntDone = 0;
    tick(1);
    checks++; if (bus.interrupt !== 2'b10) begin failures++; $display("FAIL prio_second got %b exp 10", bus.interrupt); end
    checks++; if (bus.IntVector !== 1'b1) begin failures++; $display("FAIL prio_vec got %b exp 1", bus.IntVector); end
  endtask

  task automatic test_frozen();
    do_reset();
    load_mask(2'b11);
    bus.irq_in = 2'b10;
    tick(4);
    checks++; if (bus.interrupt !== 2'b10) begin failures++; $display("FAIL frozen_init got %b exp 10", bus.interrupt); end
    bus.irq_in = 2'b11;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      checks++; if (bus.interrupt !== 2'b10) begin failures++; $display("FAIL frozen_hold cyc %0d got %b exp 10", k, bus.interrupt); end
    end
    bus.IntAck = 1; tick(1); bus.IntAck = 0;
    bus.IntDone = 1; tick(1); bus.IntDone = 0;
    tick(1);
    checks++; if (bus.interrupt !== 2'b01) begin failures++; $display("FAIL frozen_next got %b exp 01", bus.interrupt); end
    checks++; if (bus.IntVector !== 1'b0) begin failures++; $display("FAIL frozen_next_vec got %b exp 0", bus.IntVector); end
  endtask

  task automatic test_set_wins();
    do_reset();
    load_mask(2'b10);
    bus.irq_in = 2'b10;
    tick(4);
    bus.irq_in = 2'b00; tick(2);
    bus.irq_in = 2'b10; tick(2);
    checks++; if (bus.interrupt !== 2'b10) begin failures++; $display("FAIL setwin_req got %b exp 10", bus.interrupt); end
    // the new rise reaches pending on this same ack edge
    bus.IntAck = 1; tick(1); bus.IntAck = 0;
    checks++; if (bus.StatusOut !== 32'h0002_0002) begin failures++; $display("FAIL setwin_status got %h exp 00020002", bus.StatusOut); end
    bus.IntDone = 1; tick(1); bus.IntDone = 0;
    tick(1);
    checks++; if (bus.interrupt !== 2'b10) begin failures++; $display("FAIL setwin_rereq got %b exp 10", bus.interrupt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_mask(2'b11);
    bus.irq_in = 2'b11;
    tick(4);
    bus.IntAck = 1; tick(1); bus.IntAck = 0;
    checks++; if (bus.StatusOut !== 32'h0003_0002) begin failures++; $display("FAIL mid_pre_status got %h exp 00030002", bus.StatusOut); end
    Reset = 1; tick(1); Reset = 0;
    checks++; if (bus.IntActive !== 1'b0) begin failures++; $display("FAIL mid_active got %b exp 0", bus.IntActive); end
    checks++; if (bus.StatusOut !== 32'h0) begin failures++; $display("FAIL mid_status got %h exp 0", bus.StatusOut); end
    checks++; if (bus.interrupt !== 2'b00) begin failures++; $display("FAIL mid_int got %b exp 00", bus.interrupt); end
    for (int k = 0; k < 6; k++) begin
      tick(1);
      checks++; if (bus.interrupt !== 2'b00) begin failures++; $display("FAIL mid_held cyc %0d got %b exp 00", k, bus.interrupt); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      checks++; if (bus.interrupt !== (m_present ? N'(1 << m_cur) : N'(0))) begin
        failures++; $display("FAIL rnd_int cyc %0d got %b exp %b", c, bus.interrupt, m_present ? N'(1 << m_cur) : N'(0)); end
      checks++; if (bus.IntVector !== (m_present ? VW'(m_cur) : VW'(0))) begin
        failures++; $display("FAIL rnd_vec cyc %0d got %b exp %b", c, bus.IntVector, m_present ? VW'(m_cur) : VW'(0)); end
      checks++; if (bus.IntActive !== m_serv) begin
        failures++; $display("FAIL rnd_act cyc %0d got %b exp %b", c, bus.IntActive, m_serv); end
      checks++; if (bus.StatusOut !== ((32'(m_mask) << 16) | 32'(m_pend))) begin
        failures++; $display("FAIL rnd_status cyc %0d got %h exp %h", c, bus.StatusOut, (32'(m_mask) << 16) | 32'(m_pend)); end
      Reset       = ($urandom_range(0, 149) == 0);
      bus.irq_in  = bus.irq_in ^ (N'($urandom) & N'($urandom));
      bus.MaskIn  = ($urandom_range(0, 9) == 0);
      bus.BusIn   = $urandom;
      bus.IntAck  = ($urandom_range(0, 2) == 0);
      bus.IntDone = ($urandom_range(0, 2) == 0);
      tick(1);
    end
    Reset = 0;
  endtask

  initial begin
    Reset = 1; bus.irq_in = '0; bus.BusIn = '0; bus.MaskIn = 0;
    bus.IntAck = 0; bus.IntDone = 0;
    tick(2);
    test_reset();
    test_single();
    test_priority();
    test_frozen();
    test_set_wins();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
